// File: rtl/raxi2axi_master_if.sv
// AXI4 master-side bus bundle carrying one single-beat write (AW/W/B) or read (AR/R) at a time.
interface raxi2axi_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] M_AWADDR;
    logic [7:0]        M_AWLEN;
    logic              M_AWVALID;
    logic              M_AWREADY;
    logic [31:0]       M_WDATA;
    logic [3:0]        M_WSTRB;
    logic              M_WLAST;
    logic              M_WVALID;
    logic              M_WREADY;
    logic [1:0]        M_BRESP;
    logic              M_BVALID;
    logic              M_BREADY;
    logic [ADDR_W-1:0] M_ARADDR;
    logic [7:0]        M_ARLEN;
    logic              M_ARVALID;
    logic              M_ARREADY;
    logic [31:0]       M_RDATA;
    logic [1:0]        M_RRESP;
    logic              M_RLAST;
    logic              M_RVALID;
    logic              M_RREADY;

    modport master (
        output M_AWADDR, M_AWLEN, M_AWVALID, M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
               M_BREADY, M_ARADDR, M_ARLEN, M_ARVALID, M_RREADY,
        input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY,
               M_RDATA, M_RRESP, M_RLAST, M_RVALID
    );

    modport slave (
        input  M_AWADDR, M_AWLEN, M_AWVALID, M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
               M_BREADY, M_ARADDR, M_ARLEN, M_ARVALID, M_RREADY,
        output M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY,
               M_RDATA, M_RRESP, M_RLAST, M_RVALID
    );
endinterface

// File: rtl/raxi2axi_master.sv
// Turns one RAXI word request into a single-beat AXI4 write or read; one transaction in flight,
// completion reported by a one-cycle raxi_ready pulse with held read data and error status.
module raxi2axi_master #(
    parameter int         C_AXI_ADDR_WIDTH = 32,
    parameter logic [3:0] WSTRB_VALUE      = 4'hF
) (
    input  logic                    S_ACLK,
    input  logic                    S_ARESETN,
    input  logic                    raxi_wvalid,
    input  logic                    raxi_rvalid,
    input  logic [31:0]             raxi_address,
    input  logic [31:0]             raxi_wdata,
    output logic                    raxi_ready,
    output logic [31:0]             raxi_rdata,
    output logic                    raxi_error,
    output logic                    raxi_busy,
    raxi2axi_master_if.master       m_axi,
    output logic [2:0]              fsm_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_ext;

    assign fsm_state = state;

    generate
        if (C_AXI_ADDR_WIDTH > 32) begin : g_addr_zext
            assign addr_ext = {{(C_AXI_ADDR_WIDTH-32){1'b0}}, raxi_address};
        end else if (C_AXI_ADDR_WIDTH == 32) begin : g_addr_same
            assign addr_ext = raxi_address;
        end else begin : g_addr_trunc
            assign addr_ext = raxi_address[C_AXI_ADDR_WIDTH-1:0];
        end
    endgenerate

    assign m_axi.M_AWLEN = 8'd0;
    assign m_axi.M_ARLEN = 8'd0;
    assign m_axi.M_WLAST = 1'b1;
    assign m_axi.M_WSTRB = WSTRB_VALUE;

    // Handshakes: a transfer happens on a rising edge where VALID and READY are both high.
    // Our VALIDs rise only with a stable payload and fall only on the cycle after their own
    // transfer; our READYs are raised only in the state that expects that response, so an
    // early or unsolicited B/R simply waits (or is ignored in IDLE).
    always_ff @(posedge S_ACLK) begin
        if (!S_ARESETN) begin
            state            <= IDLE;
            raxi_ready       <= 1'b0;
            raxi_rdata       <= 32'd0;
            raxi_error       <= 1'b0;
            raxi_busy        <= 1'b0;
            m_axi.M_AWADDR   <= '0;
            m_axi.M_AWVALID  <= 1'b0;
            m_axi.M_WDATA    <= 32'd0;
            m_axi.M_WVALID   <= 1'b0;
            m_axi.M_BREADY   <= 1'b0;
            m_axi.M_ARADDR   <= '0;
            m_axi.M_ARVALID  <= 1'b0;
            m_axi.M_RREADY   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (raxi_wvalid) begin
                        m_axi.M_AWADDR  <= addr_ext;
                        m_axi.M_WDATA   <= raxi_wdata;
                        m_axi.M_AWVALID <= 1'b1;
                        m_axi.M_WVALID  <= 1'b1;
                        raxi_busy       <= 1'b1;
                        raxi_error      <= 1'b0;
                        state           <= WADDR;
                    end else if (raxi_rvalid) begin
                        m_axi.M_ARADDR  <= addr_ext;
                        m_axi.M_ARVALID <= 1'b1;
                        raxi_busy       <= 1'b1;
                        raxi_error      <= 1'b0;
                        state           <= RADDR;
                    end
                end
                WADDR: begin
                    if (m_axi.M_AWVALID && m_axi.M_AWREADY) m_axi.M_AWVALID <= 1'b0;
                    if (m_axi.M_WVALID && m_axi.M_WREADY)   m_axi.M_WVALID  <= 1'b0;
                    // A channel whose VALID is already low has finished its handshake earlier.
                    if ((!m_axi.M_AWVALID || m_axi.M_AWREADY) &&
                        (!m_axi.M_WVALID  || m_axi.M_WREADY)) begin
                        m_axi.M_BREADY <= 1'b1;
                        state          <= WRESP;
                    end
                end
                WRESP: begin
                    if (m_axi.M_BREADY && m_axi.M_BVALID) begin
                        m_axi.M_BREADY <= 1'b0;
                        raxi_error     <= |m_axi.M_BRESP;
                        raxi_ready     <= 1'b1;
                        state          <= DONE;
                    end
                end
                RADDR: begin
                    if (m_axi.M_ARVALID && m_axi.M_ARREADY) begin
                        m_axi.M_ARVALID <= 1'b0;
                        m_axi.M_RREADY  <= 1'b1;
                        state           <= RDATA;
                    end
                end
                RDATA: begin
                    if (m_axi.M_RREADY && m_axi.M_RVALID) begin
                        m_axi.M_RREADY <= 1'b0;
                        raxi_rdata     <= m_axi.M_RDATA;
                        raxi_error     <= (|m_axi.M_RRESP) | ~m_axi.M_RLAST;
                        raxi_ready     <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    raxi_ready <= 1'b0;
                    raxi_busy  <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raxi2axi_master.sv
// Directed bench for raxi2axi_master: scripted AXI slave responses, hand-computed expectations.
module tb_raxi2axi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        raxi_wvalid, raxi_rvalid;
    logic [31:0] raxi_address, raxi_wdata;
    logic        raxi_ready;
    logic [31:0] raxi_rdata;
    logic        raxi_error, raxi_busy;
    logic [2:0]  fsm_state;

    int n_vec = 0;
    int n_err = 0;
    int aw_hs = 0;
    int ar_seen = 0;
    int rdy_cnt = 0;
    logic [31:0] exp_q[$];

    raxi2axi_master_if #(.ADDR_W(32)) axi ();

    raxi2axi_master #(.C_AXI_ADDR_WIDTH(32), .WSTRB_VALUE(4'hF)) dut (
        .S_ACLK       (clk),
        .S_ARESETN    (rst_n),
        .raxi_wvalid  (raxi_wvalid),
        .raxi_rvalid  (raxi_rvalid),
        .raxi_address (raxi_address),
        .raxi_wdata   (raxi_wdata),
        .raxi_ready   (raxi_ready),
        .raxi_rdata   (raxi_rdata),
        .raxi_error   (raxi_error),
        .raxi_busy    (raxi_busy),
        .m_axi        (axi),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    // Bus monitors
    always @(posedge clk) begin
        if (rst_n) begin
            if (axi.M_AWVALID && axi.M_AWREADY) aw_hs <= aw_hs + 1;
            if (axi.M_ARVALID) ar_seen <= ar_seen + 1;
            if (raxi_ready) rdy_cnt <= rdy_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic slave_idle();
        axi.M_AWREADY = 1'b0;
        axi.M_WREADY  = 1'b0;
        axi.M_BRESP   = 2'b00;
        axi.M_BVALID  = 1'b0;
        axi.M_ARREADY = 1'b0;
        axi.M_RDATA   = 32'd0;
        axi.M_RRESP   = 2'b00;
        axi.M_RLAST   = 1'b0;
        axi.M_RVALID  = 1'b0;
    endtask

    task automatic req_write(input logic [31:0] a, input logic [31:0] d);
        raxi_wvalid  = 1'b1;
        raxi_address = a;
        raxi_wdata   = d;
    endtask

    task automatic req_read(input logic [31:0] a);
        raxi_rvalid  = 1'b1;
        raxi_address = a;
    endtask

    task automatic req_clear();
        raxi_wvalid = 1'b0;
        raxi_rvalid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int i;
        i = 0;
        while (raxi_ready !== 1'b1 && i < 40) begin
            step();
            i++;
        end
        check_eq(tag, raxi_ready, 1'b1);
    endtask

    task automatic check_read_done(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        check_eq(tag, raxi_rdata, e);
    endtask

    initial begin
        int aw_snap, ar_snap, rdy_snap;
        req_clear();
        raxi_address = 32'd0;
        raxi_wdata   = 32'd0;
        slave_idle();

        // Reset state
        step(); step(); step();
        check_eq("rst_state", fsm_state, 3'd0);
        check_eq("rst_busy", raxi_busy, 1'b0);
        check_eq("rst_ready", raxi_ready, 1'b0);
        check_eq("rst_error", raxi_error, 1'b0);
        check_eq("rst_rdata", raxi_rdata, 32'd0);
        check_eq("rst_valids", {axi.M_AWVALID, axi.M_WVALID, axi.M_ARVALID}, 3'b000);
        check_eq("rst_readys", {axi.M_BREADY, axi.M_RREADY}, 2'b00);
        check_eq("rst_addr", {axi.M_AWADDR, axi.M_ARADDR}, 64'd0);
        check_eq("rst_wdata", axi.M_WDATA, 32'd0);
        check_eq("const_fields", {axi.M_AWLEN, axi.M_ARLEN, axi.M_WSTRB, axi.M_WLAST},
                 {8'd0, 8'd0, 4'hF, 1'b1});
        rst_n = 1'b1;
        step();

        // Write, always-ready slave
        axi.M_AWREADY = 1'b1; axi.M_WREADY = 1'b1; axi.M_BVALID = 1'b1;
        req_write(32'h0000_0010, 32'hDEAD_BEEF);
        step();                                      // T0+1
        req_clear();
        check_eq("w1_valids", {axi.M_AWVALID, axi.M_WVALID}, 2'b11);
        check_eq("w1_awaddr", axi.M_AWADDR, 32'h10);
        check_eq("w1_wdata", axi.M_WDATA, 32'hDEAD_BEEF);
        check_eq("w1_busy", raxi_busy, 1'b1);
        check_eq("w1_bready_held", axi.M_BREADY, 1'b0);
        step();                                      // T0+2
        check_eq("w1_valids_drop", {axi.M_AWVALID, axi.M_WVALID}, 2'b00);
        check_eq("w1_bready", axi.M_BREADY, 1'b1);
        check_eq("w1_ready_early", raxi_ready, 1'b0);
        step();                                      // T0+3
        axi.M_BVALID = 1'b0;
        check_eq("w1_ready_t3", raxi_ready, 1'b1);
        check_eq("w1_error", raxi_error, 1'b0);
        check_eq("w1_busy_done", raxi_busy, 1'b1);
        step();
        check_eq("w1_ready_pulse", raxi_ready, 1'b0);
        check_eq("w1_busy_low", raxi_busy, 1'b0);
        slave_idle();

        // Read with 4 wait cycles before RVALID
        axi.M_ARREADY = 1'b1;
        exp_q.push_back(32'h1234_5678);
        req_read(32'h0000_0020);
        step();                                      // T0+1
        req_clear();
        check_eq("r1_arvalid", axi.M_ARVALID, 1'b1);
        check_eq("r1_araddr", axi.M_ARADDR, 32'h20);
        step();                                      // T0+2
        check_eq("r1_arvalid_drop", axi.M_ARVALID, 1'b0);
        check_eq("r1_rready", axi.M_RREADY, 1'b1);
        step(); step(); step();                      // T0+5
        check_eq("r1_wait_rready", axi.M_RREADY, 1'b1);
        check_eq("r1_wait_noready", raxi_ready, 1'b0);
        step();                                      // T0+6
        axi.M_RVALID = 1'b1; axi.M_RDATA = 32'h1234_5678; axi.M_RLAST = 1'b1;
        step();                                      // T0+7
        axi.M_RVALID = 1'b0;
        check_eq("r1_ready", raxi_ready, 1'b1);
        check_read_done("r1_rdata");
        check_eq("r1_error", raxi_error, 1'b0);
        check_eq("r1_rready_drop", axi.M_RREADY, 1'b0);
        step();
        check_eq("r1_ready_pulse", raxi_ready, 1'b0);
        check_eq("r1_busy_low", raxi_busy, 1'b0);
        check_eq("r1_rdata_held", raxi_rdata, 32'h1234_5678);
        slave_idle();

        // AWREADY delayed, WREADY immediate
        axi.M_WREADY = 1'b1; axi.M_BVALID = 1'b1;
        req_write(32'h0000_0040, 32'hA5A5_0001);
        step();                                      // T0+1
        req_clear();
        check_eq("w3_t1_valids", {axi.M_AWVALID, axi.M_WVALID}, 2'b11);
        step();                                      // T0+2
        check_eq("w3_t2_valids", {axi.M_AWVALID, axi.M_WVALID}, 2'b10);
        check_eq("w3_t2_bready", axi.M_BREADY, 1'b0);
        step();                                      // T0+3
        check_eq("w3_t3_awaddr", axi.M_AWADDR, 32'h40);
        step();                                      // T0+4
        check_eq("w3_t4_awvalid", axi.M_AWVALID, 1'b1);
        check_eq("w3_t4_bready", axi.M_BREADY, 1'b0);
        axi.M_AWREADY = 1'b1;
        step();                                      // T0+5
        axi.M_AWREADY = 1'b0;
        check_eq("w3_t5_awvalid", axi.M_AWVALID, 1'b0);
        check_eq("w3_t5_bready", axi.M_BREADY, 1'b1);
        rdy_snap = rdy_cnt;
        step();                                      // T0+6
        axi.M_BVALID = 1'b0;
        check_eq("w3_t6_ready", raxi_ready, 1'b1);
        step(); step();
        check_eq("w3_single_ready", rdy_cnt - rdy_snap, 1);
        check_eq("w3_busy_low", raxi_busy, 1'b0);
        slave_idle();

        // Error status: BRESP=SLVERR, then read with RLAST=0, then a clean write
        axi.M_AWREADY = 1'b1; axi.M_WREADY = 1'b1; axi.M_BVALID = 1'b1; axi.M_BRESP = 2'b10;
        req_write(32'h0000_0030, 32'h0000_0077);
        step();
        req_clear();
        wait_ready("e1_ready");
        check_eq("e1_error", raxi_error, 1'b1);
        step();
        check_eq("e1_error_held", raxi_error, 1'b1);
        slave_idle();
        axi.M_ARREADY = 1'b1; axi.M_RVALID = 1'b1; axi.M_RDATA = 32'h0000_0055;
        axi.M_RRESP = 2'b00; axi.M_RLAST = 1'b0;
        exp_q.push_back(32'h0000_0055);
        req_read(32'h0000_0034);
        step();
        req_clear();
        check_eq("e2_error_cleared", raxi_error, 1'b0);
        check_eq("e2_rready_held", axi.M_RREADY, 1'b0);
        wait_ready("e2_ready");
        check_eq("e2_error", raxi_error, 1'b1);
        check_read_done("e2_rdata");
        step();
        slave_idle();
        axi.M_AWREADY = 1'b1; axi.M_WREADY = 1'b1; axi.M_BVALID = 1'b1;
        req_write(32'h0000_0038, 32'h0000_0001);
        step();
        req_clear();
        check_eq("e3_error_cleared", raxi_error, 1'b0);
        wait_ready("e3_ready");
        check_eq("e3_error", raxi_error, 1'b0);
        step();
        slave_idle();

        // Simultaneous write+read, then a write while busy
        axi.M_AWREADY = 1'b1; axi.M_WREADY = 1'b1; axi.M_BVALID = 1'b1;
        aw_snap = aw_hs; ar_snap = ar_seen;
        req_write(32'h0000_0080, 32'h0000_0001);
        raxi_rvalid = 1'b1;
        step();                                      // T0+1
        raxi_rvalid = 1'b0;
        req_write(32'h0000_0090, 32'h0000_0002);
        check_eq("p1_state", fsm_state, 3'd1);
        check_eq("p1_arvalid", axi.M_ARVALID, 1'b0);
        step();
        req_clear();
        wait_ready("p1_ready");
        step(); step(); step();
        check_eq("p1_aw_count", aw_hs - aw_snap, 1);
        check_eq("p1_ar_none", ar_seen - ar_snap, 0);
        check_eq("p1_awaddr", axi.M_AWADDR, 32'h80);
        check_eq("p1_wdata", axi.M_WDATA, 32'h1);
        check_eq("p1_unsolicited_b", axi.M_BREADY, 1'b0);
        slave_idle();

        // Reset while in WRESP with BVALID pending
        axi.M_AWREADY = 1'b1; axi.M_WREADY = 1'b1;
        req_write(32'h0000_00C0, 32'h0BAD_F00D);
        step();                                      // T0+1
        req_clear();
        step();                                      // T0+2
        check_eq("x1_in_wresp", fsm_state, 3'd2);
        axi.M_BVALID = 1'b1;
        rst_n = 1'b0;
        rdy_snap = rdy_cnt;
        step();                                      // T0+3
        rst_n = 1'b1;
        slave_idle();
        check_eq("x1_state", fsm_state, 3'd0);
        check_eq("x1_flags", {raxi_busy, raxi_ready, raxi_error, axi.M_BREADY}, 4'b0000);
        check_eq("x1_awaddr", axi.M_AWADDR, 32'd0);
        check_eq("x1_wdata", axi.M_WDATA, 32'd0);
        step(); step();
        check_eq("x1_no_ready", rdy_cnt - rdy_snap, 0);
        axi.M_ARREADY = 1'b1; axi.M_RVALID = 1'b1; axi.M_RDATA = 32'hCAFE_F00D; axi.M_RLAST = 1'b1;
        exp_q.push_back(32'hCAFE_F00D);
        req_read(32'h0000_0100);
        step();
        req_clear();
        check_eq("x2_araddr", axi.M_ARADDR, 32'h100);
        wait_ready("x2_ready");
        check_read_done("x2_rdata");
        check_eq("x2_error", raxi_error, 1'b0);
        step();
        slave_idle();
        check_eq("x2_busy_low", raxi_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
